// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencer: opcodes, ARM condition codes, ALU controls, FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_CMP = 2'b10,
        OP_NOP = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        CC_EQ = 4'b0000, CC_NE = 4'b0001, CC_CS = 4'b0010, CC_CC = 4'b0011,
        CC_MI = 4'b0100, CC_PL = 4'b0101, CC_VS = 4'b0110, CC_VC = 4'b0111,
        CC_HI = 4'b1000, CC_LS = 4'b1001, CC_GE = 4'b1010, CC_LT = 4'b1011,
        CC_GT = 4'b1100, CC_LE = 4'b1101, CC_AL = 4'b1110, CC_NV = 4'b1111
    } cond_e;

    localparam logic [5:0] CTRL_IDLE = 6'b000000;
    localparam logic [5:0] CTRL_ADD  = 6'b000001;
    localparam logic [5:0] CTRL_SUB  = 6'b000010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/cond_eval.sv
// ARM condition-code evaluation against {N,Z,C,V}; purely combinational, no handshake.
module cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n_f, z_f, c_f, v_f;

    always_comb begin
        {n_f, z_f, c_f, v_f} = flags;
        pass = 1'b0;
        case (cond_e'(cond))
            CC_EQ: pass = z_f;
            CC_NE: pass = !z_f;
            CC_CS: pass = c_f;
            CC_CC: pass = !c_f;
            CC_MI: pass = n_f;
            CC_PL: pass = !n_f;
            CC_VS: pass = v_f;
            CC_VC: pass = !v_f;
            CC_HI: pass = c_f && !z_f;
            CC_LS: pass = !c_f || z_f;
            CC_GE: pass = (n_f == v_f);
            CC_LT: pass = (n_f != v_f);
            CC_GT: pass = !z_f && (n_f == v_f);
            CC_LE: pass = z_f || (n_f != v_f);
            CC_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issues one conditional ADD/SUB/CMP/NOP to an external ALU; out_valid 2 cycles after accept.
// One op in flight; in_ready low until the response is taken with out_ready.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [3:0]   in_cond,
    input  logic         in_setflags,
    input  logic [n-1:0] in_a,
    input  logic [n-1:0] in_b,
    output logic [5:0]   alu_control,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    input  logic [n-1:0] alu_result,
    input  logic         alu_n,
    input  logic         alu_z,
    input  logic         alu_c,
    input  logic         alu_v,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_result,
    output logic         out_exec,
    output logic [3:0]   flags
);

    state_e       state_q, state_d;
    op_e          op_q, op_d;
    logic [3:0]   cond_q, cond_d;
    logic         setflags_q, setflags_d;
    logic [n-1:0] a_q, a_d, b_q, b_d;
    logic [n-1:0] result_q, result_d;
    logic         exec_q, exec_d;
    logic [3:0]   flags_q, flags_d;
    logic         cond_pass;
    logic         do_op;

    cond_eval u_cond_eval (
        .cond  (cond_q),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cond_d      = cond_q;
        setflags_d  = setflags_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        exec_d      = exec_q;
        flags_d     = flags_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        alu_control = CTRL_IDLE;
        do_op       = cond_pass && (op_q != OP_NOP);

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d       = op_e'(in_op);
                    cond_d     = in_cond;
                    setflags_d = in_setflags;
                    a_d        = in_a;
                    b_d        = in_b;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Condition sees flags_q, so a flag write here only affects the next op.
                if (do_op) begin
                    alu_control = (op_q == OP_ADD) ? CTRL_ADD : CTRL_SUB;
                    result_d    = (op_q == OP_CMP) ? '0 : alu_result;
                    exec_d      = 1'b1;
                    if (setflags_q || (op_q == OP_CMP)) begin
                        flags_d = {alu_n, alu_z, alu_c, alu_v};
                    end
                end else begin
                    result_d = '0;
                    exec_d   = 1'b0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            cond_q     <= 4'b0000;
            setflags_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            exec_q     <= 1'b0;
            flags_q    <= 4'b0000;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cond_q     <= cond_d;
            setflags_q <= setflags_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            exec_q     <= exec_d;
            flags_q    <= flags_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign out_result = result_q;
    assign out_exec   = exec_q;
    assign flags      = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a behavioural ALU and reference model.
module tb_alu_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [3:0]   in_cond;
    logic         in_setflags;
    logic [W-1:0] in_a, in_b;
    logic [5:0]   alu_control;
    logic [W-1:0] alu_a, alu_b;
    logic [W-1:0] alu_result;
    logic         alu_n, alu_z, alu_c, alu_v;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_exec;
    logic [3:0]   flags;

    int n_checks = 0;
    int n_fail   = 0;

    // Flag override lets the bench preload any NZCV value through a CMP.
    logic       force_en   = 1'b0;
    logic [3:0] force_nzcv = 4'b0000;
    logic [3:0] mflags     = 4'b0000;

    alu_sequencer #(.n(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_cond     (in_cond),
        .in_setflags (in_setflags),
        .in_a        (in_a),
        .in_b        (in_b),
        .alu_control (alu_control),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .alu_c       (alu_c),
        .alu_v       (alu_v),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_exec    (out_exec),
        .flags       (flags)
    );

    always #5 clk = ~clk;

    // Bit-level ALU standing in for the real datapath.
    logic [W:0]   alu_sum;
    logic [W-1:0] alu_bb;
    always_comb begin
        alu_sum = '0;
        alu_bb  = alu_b;
        if (alu_control == 6'b000001) begin
            alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        end else if (alu_control == 6'b000010) begin
            alu_bb  = ~alu_b;
            alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, 1'b1};
        end
        alu_result = alu_sum[W-1:0];
        alu_n = alu_sum[W-1];
        alu_z = (alu_sum[W-1:0] == '0);
        alu_c = alu_sum[W];
        alu_v = (alu_a[W-1] == alu_bb[W-1]) && (alu_sum[W-1] != alu_a[W-1]);
        if (force_en) {alu_n, alu_z, alu_c, alu_v} = force_nzcv;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic nn, zz, cc, vv;
        {nn, zz, cc, vv} = f;
        case (c)
            4'd0:  return zz;
            4'd1:  return !zz;
            4'd2:  return cc;
            4'd3:  return !cc;
            4'd4:  return nn;
            4'd5:  return !nn;
            4'd6:  return vv;
            4'd7:  return !vv;
            4'd8:  return cc && !zz;
            4'd9:  return !cc || zz;
            4'd10: return nn == vv;
            4'd11: return nn != vv;
            4'd12: return !zz && (nn == vv);
            4'd13: return zz || (nn != vv);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Integer-range arithmetic: carry = unsigned wrap/no-borrow, overflow = signed out of range.
    function automatic void ref_alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] r, output logic [3:0] f);
        longint ua, ub, sa, sb, u, s;
        logic nn, zz, cc, vv;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'b00) begin
            u  = ua + ub;
            s  = sa + sb;
            cc = (u >= (longint'(1) << W));
        end else begin
            u  = ua - ub;
            s  = sa - sb;
            cc = (ua >= ub);
        end
        r  = u[W-1:0];
        nn = r[W-1];
        zz = (r == '0);
        vv = (s > longint'(32'h7FFFFFFF)) || (s < -(longint'(1) << (W - 1)));
        f  = {nn, zz, cc, vv};
    endfunction

    // Issues one op, checks EXEC and RESP behaviour against the model, then takes the response.
    task automatic do_op(input logic [1:0] op, input logic [3:0] cond, input logic sf,
                         input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [W-1:0] r, exp_res;
        logic [3:0]   f;
        logic         pass, run, exp_exec;
        logic [5:0]   exp_ctrl;
        int           cyc, lat;
        ref_alu(op, a, b, r, f);
        pass     = ref_cond(cond, mflags);
        run      = pass && (op != 2'b11);
        exp_ctrl = !run ? 6'b000000 : (op == 2'b00) ? 6'b000001 : 6'b000010;
        exp_res  = (run && op != 2'b10) ? r : '0;
        exp_exec = run;
        if (run && (sf || op == 2'b10)) mflags = force_en ? force_nzcv : f;

        cyc = 0;
        while (!in_ready && cyc < 10) begin
            @(posedge clk); #1; cyc++;
        end
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_op = op; in_cond = cond; in_setflags = sf; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
        chk("exec_ctrl", alu_control, exp_ctrl);
        chk("exec_alu_a", alu_a, a);
        chk("exec_alu_b", alu_b, b);
        chk("exec_in_ready", in_ready, 0);
        // Latency counted in rising edges, the accept edge included.
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, 2);
        chk("resp_ctrl", alu_control, 0);
        chk("out_result", out_result, exp_res);
        chk("out_exec", out_exec, exp_exec);
        chk("flags", flags, mflags);
        if (hold > 0) begin
            in_valid = 1'b1; in_op = 2'b00; in_cond = 4'he; in_a = ~a; in_b = ~b;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("hold_valid", out_valid, 1);
                chk("hold_result", out_result, exp_res);
                chk("hold_exec", out_exec, exp_exec);
                chk("hold_in_ready", in_ready, 0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_alu_a", alu_a, a);
    endtask

    task automatic load_flags(input logic [3:0] f);
        force_en   = 1'b1;
        force_nzcv = f;
        do_op(2'b10, 4'he, 1'b0, '0, '0, 0);
        force_en   = 1'b0;
    endtask

    initial begin
        int ones;
        logic [W-1:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; in_op = 2'b11; in_cond = 4'h0; in_setflags = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_exec", out_exec, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_ctrl", alu_control, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(2'b00, 4'h0, 1'b1, 32'd1, 32'd1, 0);
        chk("eq_fail_flags", flags, 4'b0000);
        do_op(2'b00, 4'he, 1'b1, 32'h7FFFFFFF, 32'h1, 0);
        chk("add_ovf_result", out_result, 32'h80000000);
        chk("add_ovf_flags", flags, 4'b1001);
        do_op(2'b10, 4'he, 1'b0, 32'd5, 32'd5, 0);
        chk("cmp_z", flags[2], 1);
        do_op(2'b01, 4'h0, 1'b0, 32'd9, 32'd4, 0);
        chk("sub_eq_result", out_result, 32'd5);
        do_op(2'b00, 4'he, 1'b0, 32'h1234, 32'h4321, 5);
        do_op(2'b00, 4'hf, 1'b0, 32'd1, 32'd2, 0);
        chk("nv_exec", out_exec, 0);
        do_op(2'b11, 4'he, 1'b1, 32'd3, 32'd4, 0);

        for (int fv = 0; fv < 16; fv++) begin
            for (int c = 0; c < 16; c++) begin
                load_flags(4'(fv));
                do_op(2'b00, 4'(c), 1'b0, $urandom, $urandom, 0);
            end
        end

        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = ra;
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            do_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  ra, rb, ($urandom_range(0, 9) == 0) ? 2 : 0);
        end

        load_flags(4'b0110);
        in_valid = 1'b1; in_op = 2'b01; in_cond = 4'he; in_setflags = 1'b1; in_a = 32'd0; in_b = 32'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_ctrl", alu_control, 6'b000010);
        rst = 1'b1;
        #1;
        mflags = 4'b0000;
        chk("async_in_ready", in_ready, 1);
        chk("async_ctrl", alu_control, 0);
        chk("async_flags", flags, 0);
        chk("async_alu_a", alu_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ones = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) ones++;
        end
        chk("abort_no_resp", ones, 0);
        chk("abort_flags", flags, 0);
        chk("abort_in_ready", in_ready, 1);
        do_op(2'b00, 4'he, 1'b1, 32'hFFFFFFFF, 32'h1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: n, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  issue request valid.
REQ-005 in_ready  output  1  sequencer can accept an issue request.
REQ-006 in_op  input  2  operation: 00 ADD, 01 SUB, 10 CMP (SUB, result discarded), 11 NOP.
REQ-007 in_cond  input  4  condition code, ARM encoding (0000 EQ ... 1110 AL, 1111 NV).
REQ-008 in_setflags  input  1  update flag register from ALU flags.
REQ-009 in_a, in_b  input  n  operands.
REQ-010 alu_control  output  6  one-hot ALU control: 000001 add, 000010 sub, 000000 idle.
REQ-011 alu_a, alu_b  output  n  operands driven to the ALU.
REQ-012 alu_result  input  n  ALU result (combinational from alu_a/alu_b/alu_control).
REQ-013 alu_n, alu_z, alu_c, alu_v  input  1 each  ALU flags.
REQ-014 out_valid  output  1  response valid.
REQ-015 out_ready  input  1  response consumer ready.
REQ-016 out_result  output  n  captured result (0 for CMP, NOP, or failed condition).
REQ-017 out_exec  output  1  1 = condition passed and op executed.
REQ-018 flags  output  4  architectural flag register {N,Z,C,V}.

Function
REQ-019 The block SHALL be an FSM with states IDLE, EXEC, RESP.
REQ-020 IDLE: in_ready=1; on in_valid=1 latch in_op, in_cond, in_setflags, in_a, in_b and go to EXEC.
REQ-021 Condition SHALL be evaluated in EXEC against the flag register value held at that cycle (before any update).
REQ-022 EXEC with pass and op ADD/SUB/CMP: alu_control = 000001 (ADD) or 000010 (SUB/CMP), alu_a/alu_b = latched operands; at end of EXEC capture alu_result (ADD/SUB) into out_result, set out_exec=1, go to RESP.
REQ-023 Flag register SHALL load {alu_n,alu_z,alu_c,alu_v} at end of EXEC iff pass and (in_setflags=1 or op=CMP); NOP never updates flags.
REQ-024 EXEC with fail or NOP: alu_control=000000, out_result=0, out_exec=0 (NOP with pass also out_exec=0), flags unchanged, go to RESP.
REQ-025 Outside EXEC alu_control SHALL be 000000; alu_a/alu_b SHALL hold the latched operands.
REQ-026 RESP: out_valid=1, out_result/out_exec stable until out_ready=1; on out_ready=1 go to IDLE.
REQ-027 in_ready SHALL be 0 in EXEC and RESP; latency accept-edge to out_valid = 2 cycles; max throughput one op per 3 cycles.
REQ-028 Condition NV SHALL always fail; AL always pass; ADD/SUB width n, carry/overflow taken from ALU flags only.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, in_ready=1, out_valid=0, out_exec=0, out_result=0, flags=0000, alu_control=000000, latched operands=0.
REQ-030 Reset asserted in EXEC or RESP SHALL abort the operation with no flag update and no response.

Structure
REQ-031 Shared package alu_pkg SHALL hold: op encodings, condition-code encodings, ALU control constants (CTRL_ADD=000001, CTRL_SUB=000010, CTRL_IDLE=000000), FSM state enum.
REQ-032 Condition evaluation SHALL be a combinational sub-module cond_eval (inputs cond[3:0], flags[3:0]; output pass).

Verification
REQ-033 Reset, flags=0000; issue ADD AL setflags, A=7FFFFFFF, B=1 -> out_result=80000000, out_exec=1, flags N=1 Z=0 C=0 V=1, out_valid 2 cycles after accept.
REQ-034 CMP AL A=5 B=5, then SUB EQ A=9 B=4 -> CMP out_result=0, Z=1; SUB out_exec=1, out_result=5.
REQ-035 With Z=0, ADD EQ setflags A=1 B=1 -> out_exec=0, out_result=0, flags unchanged, alu_control stays 000000.
REQ-036 out_ready held 0 for 5 cycles in RESP -> out_valid/out_result stable, in_ready=0, in_valid ignored; release -> IDLE next cycle.
REQ-037 rst pulsed during EXEC of SUB setflags A=0 B=1 -> flags=0000, out_valid never asserted, in_ready=1 after reset.
REQ-038 Condition NV with ADD A=1 B=2 -> out_exec=0; sweep all 16 cond codes vs all 16 flag values against reference model.
